// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and helpers for the response-side slave mux.
package ahblite_pkg;

    localparam int NUM_PORTS = 9;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_OK   = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    // Isolate the lowest set bit so simultaneous selects resolve to the lowest port.
    function automatic logic [NUM_PORTS-1:0] lowest_set(input logic [NUM_PORTS-1:0] v);
        return v & (~v + NUM_PORTS'(1));
    endfunction

endpackage

// File: rtl/ahblite_slave_mux_if.sv
// Bus bundle between master, decoder selects, slaves P0..P8 and the response mux.
interface ahblite_slave_mux_if;
    import ahblite_pkg::*;

    logic [1:0]           HTRANS;
    logic [NUM_PORTS-1:0] P_HSEL;
    logic [NUM_PORTS-1:0] P_HREADYOUT;
    logic [NUM_PORTS-1:0] P_HRESP;
    logic [31:0]          P_HRDATA [NUM_PORTS];
    logic                 HREADY;
    logic                 HRESP;
    logic [31:0]          HRDATA;

    modport slave (
        input  HTRANS, P_HSEL, P_HREADYOUT, P_HRESP, P_HRDATA,
        output HREADY, HRESP, HRDATA
    );

    modport master (
        output HTRANS, P_HSEL, P_HREADYOUT, P_HRESP, P_HRDATA,
        input  HREADY, HRESP, HRDATA
    );

endinterface

// File: rtl/ahblite_default_slave.sv
// Built-in default slave: answers unmapped/disabled transfers with the two-cycle ERROR.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   OK    | idle or OKAY response (HREADYOUT=1, HRESP=0)
//   ERR1  | first error cycle, stalls the bus (HREADYOUT=0, HRESP=1)
//   ERR2  | second error cycle, next address sampled (HREADYOUT=1, HRESP=1)
module ahblite_default_slave
    import ahblite_pkg::*;
(
    input  logic HCLK,
    input  logic HRESET,
    input  logic HREADY,
    input  logic sel_default_valid,
    output logic HREADYOUT,
    output logic HRESP
);

    ds_state_e state_q, state_d;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= DS_OK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state_q)
            DS_OK: begin
                if (HREADY && sel_default_valid) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = DS_ERR2;
            end
            DS_ERR2: begin
                HRESP   = HRESP_ERROR;
                state_d = (HREADY && sel_default_valid) ? DS_ERR1 : DS_OK;
            end
            default: state_d = DS_OK;
        endcase
    end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response mux: registers the data-phase owner and steers the owner's
// HREADYOUT/HRESP/HRDATA back to the master; port 9 is the built-in default slave.
module ahblite_slave_mux
    import ahblite_pkg::*;
#(
    parameter logic [NUM_PORTS-1:0] PORT_EN       = 9'h1FF,
    parameter logic [31:0]          DEFAULT_RDATA = 32'h0000_0000
) (
    input  logic                HCLK,
    input  logic                HRESET,
    ahblite_slave_mux_if.slave  bus
);

    logic [NUM_PORTS-1:0] eff_sel;
    logic [NUM_PORTS-1:0] win_sel;
    logic                 ds_valid;
    logic [NUM_PORTS:0]   sel_q, sel_d;
    logic                 ds_hreadyout;
    logic                 ds_hresp;
    logic                 hready;
    logic                 hresp;
    logic [31:0]          hrdata;

    always_comb begin
        eff_sel  = bus.P_HSEL & PORT_EN;
        win_sel  = lowest_set(eff_sel);
        ds_valid = (eff_sel == '0) && bus.HTRANS[1];
        sel_d    = {ds_valid, win_sel};
    end

    // Owner only advances on HREADY, so selects seen during wait states are dropped.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q <= '0;
        end else if (hready) begin
            sel_q <= sel_d;
        end
    end

    ahblite_default_slave u_default_slave (
        .HCLK              (HCLK),
        .HRESET            (HRESET),
        .HREADY            (hready),
        .sel_default_valid (ds_valid),
        .HREADYOUT         (ds_hreadyout),
        .HRESP             (ds_hresp)
    );

    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        hrdata = DEFAULT_RDATA;
        if (sel_q[NUM_PORTS]) begin
            hready = ds_hreadyout;
            hresp  = ds_hresp;
        end else begin
            for (int n = 0; n < NUM_PORTS; n++) begin
                if (sel_q[n]) begin
                    hready = bus.P_HREADYOUT[n];
                    hresp  = bus.P_HRESP[n];
                    hrdata = bus.P_HRDATA[n];
                end
            end
        end
    end

    assign bus.HREADY = hready;
    assign bus.HRESP  = hresp;
    assign bus.HRDATA = hrdata;

endmodule

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
- Response-side counterpart of the AHB-Lite address decoder. It takes the decoder's per-port selects, registers them at the address phase, and steers the selected slave's HRDATA/HREADYOUT/HRESP back to the master in the data phase.
- It also contains a built-in default slave. Any transfer to an unmapped or disabled region gets the two-cycle AHB-Lite ERROR response.
- It sits between the bus master (Cortex-M0 core) and slaves P0..P8 (RAMCODE, RAMDATA, WaterLight, VGA, KEYBOARD, HONGWAI, SEG, TIMER1, SUT).

Parameters:
- PORT_EN, 9'h1FF: bit n enables port n. A disabled port's HSEL is ignored, so a transfer to it goes to the default slave.
- DEFAULT_RDATA, 32'h0000_0000: HRDATA driven when no slave or the default slave owns the data phase.

Ports:
- HCLK  input  1  bus clock.
- HRESET  input  1  synchronous, active-high reset.
- HTRANS  input  2  master transfer type; bit 1 = NONSEQ/SEQ.
- Pn_HSEL (n=0..8)  input  1 each  decoder select for port n.
- Pn_HREADYOUT (n=0..8)  input  1 each  slave n ready.
- Pn_HRESP (n=0..8)  input  1 each  slave n response (0 OKAY, 1 ERROR).
- Pn_HRDATA (n=0..8)  input  32 each  slave n read data.
- HREADY  output  1  bus ready to master and fed back to all slaves.
- HRESP  output  1  bus response to master.
- HRDATA  output  32  bus read data to master.

Behaviour:
- **Address-phase sampling:** when HREADY=1 at a rising HCLK, register a one-hot data-phase owner sel_q[9:0]. Bits 0..8 are the ports; bit 9 is the default slave.
  - Effective select: eff_n = Pn_HSEL & PORT_EN[n].
  - Several eff_n high at once: the lowest index wins, with no error.
  - No eff_n high and HTRANS[1]=1: owner = default slave.
  - No eff_n high and HTRANS[1]=0 (IDLE/BUSY): sel_q = 0, no owner.
- **Wait states:** when HREADY=0, sel_q holds. Pn_HSEL and HTRANS changes during wait states are ignored.
- **Outputs by owner:**
  - Port n owns: HREADY=Pn_HREADYOUT, HRESP=Pn_HRESP, HRDATA=Pn_HRDATA. This path is combinational from slave to master, with zero added latency.
  - No owner: HREADY=1, HRESP=0, HRDATA=DEFAULT_RDATA.
  - Default slave owns: outputs come from its FSM.
- **Default-slave FSM**, states OK, ERR1, ERR2:
  - OK: outputs HREADY=1, HRESP=0. Go to ERR1 when it is sampled as the new owner for a valid transfer.
  - ERR1: outputs HREADY=0, HRESP=1, HRDATA=DEFAULT_RDATA. Always go to ERR2 next cycle.
  - ERR2: outputs HREADY=1, HRESP=1. A new address is sampled in this cycle.
    - Next state is ERR1 if that new transfer is also unmapped and valid.
    - Otherwise next state is OK, and sel_q follows the normal sampling rules.
  - Each error therefore costs exactly 2 data-phase cycles. Back-to-back unmapped transfers repeat ERR1/ERR2 with no OK cycle between them.
  - The FSM only affects outputs while sel_q[9]=1.
- **Reset:**
  - HRESET=1 at a rising edge sets sel_q=0 and FSM=OK.
  - Outputs are then HREADY=1, HRESP=0, HRDATA=DEFAULT_RDATA on the next cycle.
  - A reset asserted mid-wait-state or mid-ERR aborts the transfer. No error is carried over.
- **Slave error passthrough:** a slave error (slave drives its own two-cycle ERROR) passes through transparently; the mux adds no extra cycle.
- **Write cycles:** HRDATA content is don't-care to the master, but the mux still drives it per the rules above.

Decomposition:
- Shared package ahblite_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP_OKAY / HRESP_ERROR.
  - NUM_PORTS = 9.
  - Default-slave FSM state encoding.
- Sub-module ahblite_default_slave, containing the FSM. Inputs: HCLK, HRESET, HREADY, sel_default_valid. Outputs: its own HREADYOUT and HRESP.
- The top level contains the select register and the output mux, and treats the default slave as port 9.

Test Plan:
- **Reset:** assert HRESET for 2 cycles with all Pn_HSEL=0 -> HREADY=1, HRESP=0, HRDATA=0 on the cycle after reset.
- **Zero-wait read:** P1_HSEL=1, HTRANS=2'b10, P1_HRDATA=32'h1234_5678, P1_HREADYOUT=1 -> next cycle HRDATA=32'h1234_5678, HREADY=1, HRESP=0. P0's data must not appear.
- **Wait states:** P3 selected, then P3_HREADYOUT=0 for 3 cycles.
  - HREADY=0 for 3 cycles.
  - Pulse P5_HSEL mid-wait -> no effect.
  - P3_HRDATA is delivered on the 4th cycle.
- **Unmapped address:** all HSEL=0, HTRANS=NONSEQ -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then OK.
  - Repeat back-to-back -> ERR1, ERR2, ERR1, ERR2.
- **Disabled port and collision:**
  - PORT_EN=9'h0FF with P8_HSEL=1 -> 2-cycle ERROR.
  - P2_HSEL=P4_HSEL=1 -> P2's data is routed.
- **Reset mid-ERR1:** assert HRESET during ERR1 -> the following cycle shows HREADY=1, HRESP=0.
